// File: rtl/vga_timing_gen_if.sv
`default_nettype none
// ============================================================================
//  Module   : vga_timing_gen_if
//  Purpose  : Configuration port of the video timing generator. Writes land
//             in the generator's pending register set; cfg_pending_o reports
//             that the pending set has been written since the last swap.
//  Ports    : cfg_wr_i      write strobe
//             cfg_sel_i     field select (0-3 H, 4-7 V, 8 polarity)
//             cfg_data_i    write data
//             cfg_pending_o pending set not yet applied
//  Revision : 1.0  initial release
// ============================================================================
interface vga_timing_gen_if #(
    parameter int CNT_W = 12
);
    logic             cfg_wr_i;
    logic [3:0]       cfg_sel_i;
    logic [CNT_W-1:0] cfg_data_i;
    logic             cfg_pending_o;

    modport master (
        output cfg_wr_i,
        output cfg_sel_i,
        output cfg_data_i,
        input  cfg_pending_o
    );

    modport slave (
        input  cfg_wr_i,
        input  cfg_sel_i,
        input  cfg_data_i,
        output cfg_pending_o
    );
endinterface
`default_nettype wire

// File: rtl/vga_timing_gen.sv
`default_nettype none
// ============================================================================
//  Module   : vga_timing_gen
//  Purpose  : Programmable two-axis video timing generator. Counts pixels and
//             lines on a pixel strobe and produces sync, data-enable, pixel
//             coordinates and line/frame/vblank start pulses. Timing is
//             double-buffered and swapped in only at the end of a frame.
//  Ports    : clk, rst         clock, synchronous active-high reset
//             pix_en_i         pixel strobe
//             cfg              configuration port (slave modport)
//             hsync_o/vsync_o  sync outputs at programmed polarity
//             de_o, x_o, y_o   active-area enable and coordinates
//             line_start_o, frame_start_o, vblank_start_o  one-clk pulses
//  Revision : 1.0  initial release
// ============================================================================
module vga_timing_gen #(
    parameter int unsigned CNT_W        = 12,
    parameter int unsigned DEF_H_ACTIVE = 640,
    parameter int unsigned DEF_H_FP     = 16,
    parameter int unsigned DEF_H_SYNC   = 96,
    parameter int unsigned DEF_H_BP     = 48,
    parameter int unsigned DEF_V_ACTIVE = 480,
    parameter int unsigned DEF_V_FP     = 10,
    parameter int unsigned DEF_V_SYNC   = 2,
    parameter int unsigned DEF_V_BP     = 33,
    parameter bit          DEF_H_POL    = 1'b0,
    parameter bit          DEF_V_POL    = 1'b0
) (
    input  wire              clk,
    input  wire              rst,
    input  wire              pix_en_i,
    vga_timing_gen_if.slave  cfg,
    output logic             hsync_o,
    output logic             vsync_o,
    output logic             de_o,
    output logic [CNT_W-1:0] x_o,
    output logic [CNT_W-1:0] y_o,
    output logic             line_start_o,
    output logic             frame_start_o,
    output logic             vblank_start_o
);
    localparam int TOT_W = CNT_W + 2;

    // Field order: 0-3 H_ACTIVE/FP/SYNC/BP, 4-7 V_ACTIVE/FP/SYNC/BP.
    localparam logic [7:0][CNT_W-1:0] c_def_timing = {
        CNT_W'(DEF_V_BP), CNT_W'(DEF_V_SYNC), CNT_W'(DEF_V_FP), CNT_W'(DEF_V_ACTIVE),
        CNT_W'(DEF_H_BP), CNT_W'(DEF_H_SYNC), CNT_W'(DEF_H_FP), CNT_W'(DEF_H_ACTIVE)
    };
    localparam logic [1:0] c_def_pol = {DEF_V_POL, DEF_H_POL};

    logic [CNT_W-1:0]      h_q, h_d, v_q, v_d;
    logic [7:0][CNT_W-1:0] act_q, act_d, pend_q, pend_d;
    logic [1:0]            pol_act_q, pol_act_d, pol_pend_q, pol_pend_d;
    logic                  pending_q, pending_d;
    // Set by reset so the first post-reset cycle presents the h=0,v=0 state
    // without needing a pixel strobe.
    logic                  fresh_q;
    logic                  hsync_q, hsync_d, vsync_q, vsync_d, de_q, de_d;
    logic [CNT_W-1:0]      x_q, x_d, y_q, y_d;
    logic                  line_q, line_d, frame_q, frame_d, vblank_q, vblank_d;

    logic [TOT_W-1:0]      w_h_tot, w_v_tot;
    logic [TOT_W-1:0]      w_hs_lo, w_hs_hi, w_vs_lo, w_vs_hi;
    logic                  w_adv, w_upd, w_h_last, w_v_last, w_frame_end;
    logic                  w_cfg_ok, w_in_hs, w_in_vs;
    logic [CNT_W-1:0]      w_cfg_fld;

    always_comb begin
        w_h_tot = TOT_W'(act_q[0]) + TOT_W'(act_q[1]) + TOT_W'(act_q[2]) + TOT_W'(act_q[3]);
        w_v_tot = TOT_W'(act_q[4]) + TOT_W'(act_q[5]) + TOT_W'(act_q[6]) + TOT_W'(act_q[7]);
        w_adv       = pix_en_i && !fresh_q;
        w_upd       = w_adv || fresh_q;
        w_h_last    = (TOT_W'(h_q) == w_h_tot - TOT_W'(1));
        w_v_last    = (TOT_W'(v_q) == w_v_tot - TOT_W'(1));
        w_frame_end = w_adv && w_h_last && w_v_last;

        // Counters
        h_d = h_q;
        v_d = v_q;
        if (w_adv) begin
            if (w_h_last) begin
                h_d = '0;
                v_d = w_v_last ? '0 : v_q + CNT_W'(1);
            end else begin
                h_d = h_q + CNT_W'(1);
            end
        end

        // Swap takes the pending set as it was before any same-cycle write.
        act_d     = w_frame_end ? pend_q : act_q;
        pol_act_d = w_frame_end ? pol_pend_q : pol_act_q;

        // Pending set; zero-length regions are stored as one.
        w_cfg_ok   = cfg.cfg_wr_i && (cfg.cfg_sel_i <= 4'd8);
        w_cfg_fld  = (cfg.cfg_data_i == '0) ? CNT_W'(1) : cfg.cfg_data_i;
        pend_d     = pend_q;
        pol_pend_d = pol_pend_q;
        pending_d  = w_frame_end ? 1'b0 : pending_q;
        if (w_cfg_ok) begin
            if (cfg.cfg_sel_i == 4'd8) begin
                pol_pend_d = cfg.cfg_data_i[1:0];
            end else begin
                pend_d[cfg.cfg_sel_i[2:0]] = w_cfg_fld;
            end
            pending_d = 1'b1;
        end

        // Outputs are decoded from the post-update counters and timing set.
        w_hs_lo = TOT_W'(act_d[0]) + TOT_W'(act_d[1]);
        w_hs_hi = w_hs_lo + TOT_W'(act_d[2]);
        w_vs_lo = TOT_W'(act_d[4]) + TOT_W'(act_d[5]);
        w_vs_hi = w_vs_lo + TOT_W'(act_d[6]);
        w_in_hs = (TOT_W'(h_d) >= w_hs_lo) && (TOT_W'(h_d) < w_hs_hi);
        w_in_vs = (TOT_W'(v_d) >= w_vs_lo) && (TOT_W'(v_d) < w_vs_hi);

        hsync_d  = hsync_q;
        vsync_d  = vsync_q;
        de_d     = de_q;
        x_d      = x_q;
        y_d      = y_q;
        line_d   = 1'b0;
        frame_d  = 1'b0;
        vblank_d = 1'b0;
        if (w_upd) begin
            hsync_d  = w_in_hs ~^ pol_act_d[0];
            vsync_d  = w_in_vs ~^ pol_act_d[1];
            de_d     = (h_d < act_d[0]) && (v_d < act_d[4]);
            x_d      = de_d ? h_d : '0;
            y_d      = de_d ? v_d : '0;
            line_d   = (h_d == '0);
            frame_d  = (h_d == '0) && (v_d == '0);
            vblank_d = (h_d == '0) && (v_d == act_d[4]);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            h_q        <= '0;
            v_q        <= '0;
            act_q      <= c_def_timing;
            pend_q     <= c_def_timing;
            pol_act_q  <= c_def_pol;
            pol_pend_q <= c_def_pol;
            pending_q  <= 1'b0;
            fresh_q    <= 1'b1;
            hsync_q    <= ~DEF_H_POL;
            vsync_q    <= ~DEF_V_POL;
            de_q       <= 1'b0;
            x_q        <= '0;
            y_q        <= '0;
            line_q     <= 1'b0;
            frame_q    <= 1'b0;
            vblank_q   <= 1'b0;
        end else begin
            h_q        <= h_d;
            v_q        <= v_d;
            act_q      <= act_d;
            pend_q     <= pend_d;
            pol_act_q  <= pol_act_d;
            pol_pend_q <= pol_pend_d;
            pending_q  <= pending_d;
            fresh_q    <= 1'b0;
            hsync_q    <= hsync_d;
            vsync_q    <= vsync_d;
            de_q       <= de_d;
            x_q        <= x_d;
            y_q        <= y_d;
            line_q     <= line_d;
            frame_q    <= frame_d;
            vblank_q   <= vblank_d;
        end
    end

    assign cfg.cfg_pending_o = pending_q;
    assign hsync_o           = hsync_q;
    assign vsync_o           = vsync_q;
    assign de_o              = de_q;
    assign x_o               = x_q;
    assign y_o               = y_q;
    assign line_start_o      = line_q;
    assign frame_start_o     = frame_q;
    assign vblank_start_o    = vblank_q;
endmodule
`default_nettype wire

// File: doc/vga_timing_gen.md
# vga_timing_gen

Programmable two-axis video timing generator for the display path. Produces hsync, vsync, data-enable and pixel coordinates from a single pixel strobe. Horizontal and vertical timing are runtime-programmable through a small register port. New settings are double-buffered and take effect only at a frame boundary, so mode changes never produce a torn frame. It sits between the pixel-clock enable source and the framebuffer read / pixel output stage.

## Interface
- CNT_W, 12, width of each axis counter and each timing field
- DEF_H_ACTIVE / DEF_H_FP / DEF_H_SYNC / DEF_H_BP, 640 / 16 / 96 / 48, reset horizontal timing
- DEF_V_ACTIVE / DEF_V_FP / DEF_V_SYNC / DEF_V_BP, 480 / 10 / 2 / 33, reset vertical timing
- DEF_H_POL / DEF_V_POL, 0 / 0, reset sync polarity (1 = active-high pulse)

- clk  in  1  clock
- rst  in  1  synchronous, active-high reset
- pix_en_i  in  1  pixel strobe; counters advance only when high
- cfg_wr_i  in  1  write strobe into the pending register set
- cfg_sel_i  in  4  field select: 0-3 H_ACTIVE/FP/SYNC/BP, 4-7 V_ACTIVE/FP/SYNC/BP, 8 polarity ({V_POL,H_POL} in bits 1:0); 9-15 ignored
- cfg_data_i  in  CNT_W  write data
- cfg_pending_o  out  1  pending set differs from active set (written since last swap)
- hsync_o, vsync_o  out  1  sync outputs at programmed polarity
- de_o  out  1  inside active area on both axes
- x_o, y_o  out  CNT_W  pixel coordinates; 0 outside the active area
- line_start_o  out  1  one-cycle pulse, first pixel of each line
- frame_start_o  out  1  one-cycle pulse, first pixel of each frame
- vblank_start_o  out  1  one-cycle pulse, first pixel of line V_ACTIVE

## Operation
- Totals: H_TOT = H_ACTIVE+H_FP+H_SYNC+H_BP; V_TOT likewise. They are computed in CNT_W+2 bits. A total greater than 2^CNT_W is a configuration error. Behaviour is undefined, and the check is done in the bench, not in hardware.
- A field written as 0 is stored as 1. Every region is at least one pixel/line.
- h counts 0..H_TOT-1 on pix_en_i. At H_TOT-1 it wraps to 0 and v advances. v counts 0..V_TOT-1 and wraps to 0.
- Frame end = pix_en_i high with h==H_TOT-1 and v==V_TOT-1. In that cycle the active set is loaded from the pending set and cfg_pending_o clears. The next frame uses the new timing from h=0, v=0.
- Horizontal sync region: H_ACTIVE+H_FP <= h < H_ACTIVE+H_FP+H_SYNC. The vertical sync region is defined the same way on v. Outputs: hsync_o = in_region XNOR H_POL, vsync_o = in_region XNOR V_POL.
- de_o = (h<H_ACTIVE)&&(v<V_ACTIVE). x_o = de_o ? h : 0. y_o = de_o ? v : 0.
- Pulses: line_start_o when h==0; frame_start_o when h==0&&v==0; vblank_start_o when h==0&&v==V_ACTIVE. Each pulse is high only in the cycle after the counter reaches that state, so it lasts one clk regardless of pix_en_i spacing.
- Config write to a selector of 9-15 is dropped and does not set cfg_pending_o.
- Config write in the same cycle as frame end: the swap uses the pending contents from before the write. The write lands in pending, cfg_pending_o stays 1, and the value applies at the following frame end.

## Timing
- All outputs are registered. They reflect the counter state after the most recent update, with 1 clk latency from the pix_en_i edge that moved the counters.
- Between pixel strobes, outputs hold their values, except the three pulses, which fall after one clk.
- Reset: h=v=0; active and pending sets = DEF_*; cfg_pending_o=0; de_o=0; x_o=y_o=0; all pulses 0; hsync_o=!DEF_H_POL, vsync_o=!DEF_V_POL.
- First cycle after rst drops: outputs show h=0, v=0 (de_o=1, frame_start_o=1, line_start_o=1) without waiting for pix_en_i.
- Reset mid-frame aborts the frame immediately. Pending writes are discarded.
- Writes are accepted every clk, and back-to-back writes are allowed. The last write to a field before the swap wins.

## Test plan
- Reset, DEF_*, pix_en_i tied high, one full frame -> 420000 pixel strobes between frame_start_o pulses; 307200 de_o cycles; hsync_o low for exactly h=656..751 each line; vsync_o low for exactly lines 490..491.
- Program H=4/1/2/1, V=3/1/1/1, pol=2'b11 mid-frame -> cfg_pending_o=1; current frame stays 800x525. Next frame is 8x6 and 48 strobes long. hsync_o is high at h=5,6; vsync_o is high at v=4; de_o is active for 12 pixels.
- pix_en_i every 3rd clk with the 8x6 mode -> x_o sequence 0,1,2,3 each held 3 clk; line_start_o and frame_start_o are each 1 clk wide.
- Write H_ACTIVE=2 in the exact frame-end cycle -> the swap uses the old pending set; cfg_pending_o remains 1; H_ACTIVE=2 appears one frame later.
- Write 0 to V_SYNC, then cfg_sel_i=12 -> V_SYNC applied as 1 line; the sel-12 write is ignored and cfg_pending_o is set only by the V_SYNC write.
- Assert rst at h=300, v=200 with a pending write -> next cycle outputs match the reset values above; the following frame runs DEF timing.
